// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment driver: active-low segment
// patterns (seg[0]=a .. seg[6]=g) and the all-dark anode word.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Nibble to segment pattern lookup
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame input snapshot.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       dp_snap_q, dp_snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick_s;
  logic [3:0]       nibble_s;
  logic [6:0]       dec_seg_s;
  logic             lz_dark_s;
  logic             an_on_s;

  assign tick_s   = (cnt_q == CNT_LAST);
  assign nibble_s = snap_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd_i (nibble_s),
    .seg_o (dec_seg_s)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= CNT_ZERO;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      dp_snap_q <= 4'b0000;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  // Slot counter, digit index and frame-boundary snapshot
  always_comb begin
    cnt_d     = tick_s ? CNT_ZERO : cnt_q + CNT_W'(1);
    idx_d     = tick_s ? idx_q + 2'd1 : idx_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    if (tick_s && (idx_q == 2'd3)) begin
      snap_d    = digits;
      dp_snap_d = dp_en;
    end else begin
      snap_d    = snap_q;
      dp_snap_d = dp_snap_q;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit goes dark when it and every digit to its left are zero
  always_comb begin
    lz_dark_s = 1'b0;
    case (idx_q)
      2'd3:    lz_dark_s = (snap_q[15:12] == 4'h0);
      2'd2:    lz_dark_s = (snap_q[15:8]  == 8'h00);
      2'd1:    lz_dark_s = (snap_q[15:4]  == 12'h000);
      default: lz_dark_s = 1'b0;
    endcase
  end
`else
  assign lz_dark_s = 1'b0;
`endif

  // Output decode; the cnt==0 cycle is the anti-ghosting dead time
  always_comb begin
    an_on_s = !blank && (cnt_q != CNT_ZERO) && !lz_dark_s;
    an_d    = an_on_s ? ~(4'b0001 << idx_q) : AN_OFF;
    seg_d   = blank ? SEG_OFF : dec_seg_s;
    dp_d    = an_on_s ? ~dp_snap_q[idx_q] : 1'b1;
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with REFRESH_DIV=4 (16 clocks per frame).
module tb_seg7_mux_driver;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  seg7_mux_driver #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .digits (digits),
    .dp_en  (dp_en),
    .blank  (blank),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One 4-clock slot: dead cycle, then the lit digit, then two hold cycles
  task automatic run_slot(input string tag, input logic [3:0] exp_an,
                          input logic [6:0] exp_seg, input logic exp_dp);
    step();
    chk({tag, "_dead_an"}, {3'b000, an}, 7'h0F);
    chk({tag, "_dead_dp"}, {6'b000000, dp}, 7'h01);
    step();
    chk({tag, "_an"}, {3'b000, an}, {3'b000, exp_an});
    if (exp_an != 4'b1111) chk({tag, "_seg"}, seg, exp_seg);
    chk({tag, "_dp"}, {6'b000000, dp}, {6'b000000, exp_dp});
    step();
    chk({tag, "_hold_an"}, {3'b000, an}, {3'b000, exp_an});
    step();
  endtask

  initial begin
    reset  = 1'b1;
    digits = 16'h0000;
    dp_en  = 4'b0000;
    blank  = 1'b0;
    step(); step(); step();
    chk("rst_an",  {3'b000, an}, 7'h0F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp",  {6'b000000, dp}, 7'h01);
    reset = 1'b0;

    // Frame 0: zero snapshot; new digits are only latched at frame end
    run_slot("f0s0", 4'b1110, 7'h40, 1'b1);
    digits = 16'h1234;
    dp_en  = 4'b0100;
    run_slot("f0s1", 4'b1101, 7'h40, 1'b1);
    run_slot("f0s2", 4'b1011, 7'h40, 1'b1);
    run_slot("f0s3", 4'b0111, 7'h40, 1'b1);

    // Frames 1 and 2: 1234 with decimal point on digit 2
    for (int f = 0; f < 2; f++) begin
      run_slot("f12s0", 4'b1110, 7'h19, 1'b1);
      run_slot("f12s1", 4'b1101, 7'h30, 1'b1);
      run_slot("f12s2", 4'b1011, 7'h24, 1'b0);
      run_slot("f12s3", 4'b0111, 7'h79, 1'b1);
    end

    // Frame 3: mid-frame change must not disturb slots 2 and 3
    run_slot("f3s0", 4'b1110, 7'h19, 1'b1);
    digits = 16'h5678;
    run_slot("f3s1", 4'b1101, 7'h30, 1'b1);
    run_slot("f3s2", 4'b1011, 7'h24, 1'b0);
    run_slot("f3s3", 4'b0111, 7'h79, 1'b1);

    // Frame 4: 5678
    run_slot("f4s0", 4'b1110, 7'h00, 1'b1);
    digits = 16'hA00F;
    dp_en  = 4'b0000;
    run_slot("f4s1", 4'b1101, 7'h78, 1'b1);
    run_slot("f4s2", 4'b1011, 7'h02, 1'b0);
    run_slot("f4s3", 4'b0111, 7'h12, 1'b1);

    // Frame 5: non-BCD nibbles shown as dashes
    run_slot("f5s0", 4'b1110, 7'h3F, 1'b1);
    digits = 16'h4321;
    run_slot("f5s1", 4'b1101, 7'h40, 1'b1);
    run_slot("f5s2", 4'b1011, 7'h40, 1'b1);
    run_slot("f5s3", 4'b0111, 7'h3F, 1'b1);

    // Frame 6: blank for 5 clocks starting mid-slot 1, spanning a tick
    run_slot("f6s0", 4'b1110, 7'h79, 1'b1);
    step();
    chk("f6s1_dead_an", {3'b000, an}, 7'h0F);
    step();
    chk("f6s1_an",  {3'b000, an}, 7'h0D);
    chk("f6s1_seg", seg, 7'h24);
    blank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("blank_an",  {3'b000, an}, 7'h0F);
      chk("blank_seg", seg, 7'h7F);
      chk("blank_dp",  {6'b000000, dp}, 7'h01);
    end
    blank = 1'b0;
    step();
    chk("post_blank_an",  {3'b000, an}, 7'h0B);
    chk("post_blank_seg", seg, 7'h30);
    chk("post_blank_dp",  {6'b000000, dp}, 7'h01);
    run_slot("f6s3", 4'b0111, 7'h19, 1'b1);

    // Frame 7: 4321 continues, no slot repeated
    run_slot("f7s0", 4'b1110, 7'h79, 1'b1);
    digits = 16'h0007;
    run_slot("f7s1", 4'b1101, 7'h24, 1'b1);
    run_slot("f7s2", 4'b1011, 7'h30, 1'b1);
    run_slot("f7s3", 4'b0111, 7'h19, 1'b1);

    // Frame 8: 0007, leading zeros dark only when suppression is built in
    run_slot("f8s0", 4'b1110, 7'h78, 1'b1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_slot("f8s1", 4'b1111, 7'h40, 1'b1);
    run_slot("f8s2", 4'b1111, 7'h40, 1'b1);
    run_slot("f8s3", 4'b1111, 7'h40, 1'b1);
`else
    run_slot("f8s1", 4'b1101, 7'h40, 1'b1);
    run_slot("f8s2", 4'b1011, 7'h40, 1'b1);
    run_slot("f8s3", 4'b0111, 7'h40, 1'b1);
`endif

    // Reset mid-frame: frame abandoned, restart on digit 0 of a zero snapshot
    run_slot("f9s0", 4'b1110, 7'h78, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_an",  {3'b000, an}, 7'h0F);
    chk("rst_mid_seg", seg, 7'h7F);
    chk("rst_mid_dp",  {6'b000000, dp}, 7'h01);
    reset = 1'b0;
    run_slot("rst_s0", 4'b1110, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
